mult_booth_seq: RTL and testbench

- Sequential signed multiplier; the inverse-operation counterpart to the ALU's iterative non-restoring divide datapath.
- Uses radix-4 modified Booth recoding: two multiplier bits retired per cycle, one shared add/subtract of 0, ±M or ±2M into the upper half of a product/multiplier shift register.
- Sits beside the divider in the ALU multdiv unit and presents the same start/ready style handshake to the pipeline.

---
 rtl/mult_booth_seq_if.sv | 49 ++++
 rtl/mult_booth_seq.sv | 128 ++++++++++++
 tb/tb_mult_booth_seq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_booth_seq_if.sv
// Start/result bundle between the pipeline and the radix-4 Booth multiplier.
// With MULT_HI_EN defined, the upper product word data_resultHi is added.
//
// Handshake: the master raises ctrl_MULT for one cycle with data_operandA/B
// valid on that same edge. The slave accepts it whenever busy is low, even in
// the completion cycle. The slave ignores ctrl_MULT while busy is high. The
// slave pulses data_resultRDY for exactly one cycle when data_result and
// data_exception (and data_resultHi) are valid. Those values then hold until
// the next completion or reset.
interface mult_booth_seq_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
`ifdef MULT_HI_EN
    logic [WIDTH-1:0] data_resultHi;
`endif

    modport master (
        output ctrl_MULT,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
`ifdef MULT_HI_EN
        input  data_resultHi,
`endif
        input  busy
    );

    modport slave (
        input  ctrl_MULT,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY,
`ifdef MULT_HI_EN
        output data_resultHi,
`endif
        output busy
    );
endinterface

// File: rtl/mult_booth_seq.sv
// Sequential signed multiplier using radix-4 modified Booth recoding.
// Each cycle retires two multiplier bits. One shared add/subtract of 0, +-M or
// +-2M goes into the upper half of a {product, multiplier, guard} shift
// register. Optional macro MULT_HI_EN exposes the upper product word.
// state_dbg mirrors the FSM state (IDLE=0, RUN=1, DONE=2).
module mult_booth_seq #(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    mult_booth_seq_if.slave   bus,
    output logic [1:0]        state_dbg
);
    localparam int PW    = 2 * WIDTH + 1;   // product/multiplier/guard register
    localparam int AW    = WIDTH + 2;       // guard accumulator width
    localparam int STEPS = WIDTH / 2;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;
    logic             busy_q;
`ifdef MULT_HI_EN
    logic [WIDTH-1:0] hi_q;
`endif

    logic [AW-1:0] m_ext;
    logic [AW-1:0] mag;
    logic          neg;
    logic [AW-1:0] upper_ext;
    logic [AW-1:0] acc;
    logic [PW-1:0] next_prod;
    logic          ovf;

    assign m_ext     = {{2{mcand[WIDTH-1]}}, mcand};
    assign upper_ext = {{2{prod[PW-1]}}, prod[PW-1:WIDTH+1]};

    // Booth radix-4 recoding of the low three register bits into a term magnitude and sign.
    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (prod[2:0])
            3'b001, 3'b010: mag = m_ext;
            3'b011:         mag = m_ext << 1;
            3'b100: begin
                mag = m_ext << 1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = m_ext;
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
    end

    // Subtraction reuses the adder: invert the term and feed carry-in of one.
    // The two guard bits absorb +-2M even when M is the most negative value.
    // Dropping the top two accumulator bits therefore loses no information.
    assign acc       = upper_ext + (mag ^ {AW{neg}}) + AW'(neg);
    assign next_prod = {acc, prod[WIDTH:2]};

    // Overflow when product bits [2W-1:W-1] are not a pure sign extension.
    assign ovf = ~((&next_prod[PW-1:WIDTH]) | ~(|next_prod[PW-1:WIDTH]));

    // FSM, shift register and registered result outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            mcand    <= '0;
            prod     <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MULT_HI_EN
            hi_q     <= '0;
`endif
        end else begin
            rdy_q <= 1'b0;
            case (state)
                RUN: begin
                    prod  <= next_prod;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state    <= DONE;
                        result_q <= next_prod[WIDTH:1];
                        exc_q    <= ovf;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b0;
`ifdef MULT_HI_EN
                        hi_q     <= next_prod[PW-1:WIDTH+1];
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    if (bus.ctrl_MULT) begin
                        mcand  <= bus.data_operandA;
                        prod   <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
                        count  <= '0;
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;
`ifdef MULT_HI_EN
    assign bus.data_resultHi  = hi_q;
`endif
    assign state_dbg          = state;
endmodule

// File: tb/tb_mult_booth_seq.sv
// Bench for mult_booth_seq: reference model built on 64-bit signed multiply,
// per-cycle output compare, directed vectors with literal expectations.
module tb_mult_booth_seq;
    localparam int W   = 32;
    localparam int LAT = W / 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    mult_booth_seq_if #(.WIDTH(W)) bus();
    logic [1:0] state_dbg;

    mult_booth_seq #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    int   checks = 0;
    int   errors = 0;
    logic check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Entry layout: {exception, 64-bit signed product}.
    logic [2*W:0] exp_q[$];
    logic [W-1:0] m_res  = '0;
    logic         m_exc  = 1'b0;
    logic         m_rdy  = 1'b0;
    logic         m_busy = 1'b0;
    int           m_rem  = 0;
`ifdef MULT_HI_EN
    logic [W-1:0] m_hi   = '0;
`endif

    function automatic logic [2*W:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        longint      p;
        logic [63:0] pu;
        logic        e;
        p  = longint'($signed(a)) * longint'($signed(b));
        pu = p;
        e  = !((pu[63:31] == 33'h0) || (pu[63:31] == {33{1'b1}}));
        return {e, pu};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_rem  <= 0;
            m_rdy  <= 1'b0;
            m_busy <= 1'b0;
            m_res  <= '0;
            m_exc  <= 1'b0;
`ifdef MULT_HI_EN
            m_hi   <= '0;
`endif
            exp_q.delete();
        end else begin
            m_rdy <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_res  <= exp_q[0][W-1:0];
                    m_exc  <= exp_q[0][2*W];
`ifdef MULT_HI_EN
                    m_hi   <= exp_q[0][2*W-1:W];
`endif
                    m_rdy  <= 1'b1;
                    m_busy <= 1'b0;
                    void'(exp_q.pop_front());
                end
            end else if (bus.ctrl_MULT) begin
                exp_q.push_back(ref_mult(bus.data_operandA, bus.data_operandB));
                m_rem  <= LAT;
                m_busy <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (check_en) begin
            check("cmp_result", 64'(bus.data_result), 64'(m_res));
            check("cmp_exception", 64'(bus.data_exception), 64'(m_exc));
            check("cmp_rdy", 64'(bus.data_resultRDY), 64'(m_rdy));
            check("cmp_busy", 64'(bus.busy), 64'(m_busy));
`ifdef MULT_HI_EN
            check("cmp_result_hi", 64'(bus.data_resultHi), 64'(m_hi));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Returns the number of negedges until RDY is seen, or -1 on timeout.
    task automatic wait_rdy(output int lat, input int limit);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout actual=none expected=pulse within %0d cycles", limit);
        end
    endtask

    logic [W-1:0] corners [6];

    function automatic logic [W-1:0] pick();
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'hFFFF_FFFE;

        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        @(negedge clock);
        check_en = 1'b1;
        @(negedge clock);
        check("reset_result", 64'(bus.data_result), 64'h0);
        check("reset_exception", 64'(bus.data_exception), 64'h0);
        check("reset_rdy", 64'(bus.data_resultRDY), 64'h0);
        check("reset_busy", 64'(bus.busy), 64'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // 3 * 5
        start(32'd3, 32'd5);
        check("busy_after_start", 64'(bus.busy), 64'h1);
        wait_rdy(lat, 40);
        check("lat_3x5", 64'(lat), 64'(LAT));
        check("res_3x5", 64'(bus.data_result), 64'd15);
        check("exc_3x5", 64'(bus.data_exception), 64'h0);
        check("busy_at_rdy", 64'(bus.busy), 64'h0);
        @(negedge clock);
        check("rdy_one_cycle", 64'(bus.data_resultRDY), 64'h0);
        check("res_held", 64'(bus.data_result), 64'd15);

        // -7 * 6
        start(32'hFFFF_FFF9, 32'd6);
        wait_rdy(lat, 40);
        check("res_m7x6", 64'(bus.data_result), 64'hFFFF_FFD6);
        check("exc_m7x6", 64'(bus.data_exception), 64'h0);
`ifdef MULT_HI_EN
        check("hi_m7x6", 64'(bus.data_resultHi), 64'hFFFF_FFFF);
`endif

        // overflow cases
        start(32'h7FFF_FFFF, 32'd2);
        wait_rdy(lat, 40);
        check("res_max_x2", 64'(bus.data_result), 64'hFFFF_FFFE);
        check("exc_max_x2", 64'(bus.data_exception), 64'h1);
        start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy(lat, 40);
        check("res_min_xm1", 64'(bus.data_result), 64'h8000_0000);
        check("exc_min_xm1", 64'(bus.data_exception), 64'h1);
`ifdef MULT_HI_EN
        check("hi_min_xm1", 64'(bus.data_resultHi), 64'h0);
`endif
        // min * min exercises the -2M term with the most negative multiplicand
        start(32'h8000_0000, 32'h8000_0000);
        wait_rdy(lat, 40);
        check("res_min_xmin", 64'(bus.data_result), 64'h0);
        check("exc_min_xmin", 64'(bus.data_exception), 64'h1);
        @(negedge clock);

        // ctrl_MULT ignored while running; back-to-back start in DONE cycle
        start(32'd4, 32'd4);
        repeat (4) @(negedge clock);
        start(32'd9, 32'd9);
        wait_rdy(lat, 40);
        check("lat_ignored_start", 64'(lat + 5), 64'(LAT));
        check("res_4x4", 64'(bus.data_result), 64'd16);
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rdy(lat, 40);
        check("lat_b2b", 64'(lat), 64'(LAT));
        check("res_m1xm1", 64'(bus.data_result), 64'd1);
        check("exc_m1xm1", 64'(bus.data_exception), 64'h0);
        @(negedge clock);

        // asynchronous reset mid-operation
        start(32'd100, 32'd100);
        repeat (7) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_result", 64'(bus.data_result), 64'h0);
        check("async_rst_busy", 64'(bus.busy), 64'h0);
        check("async_rst_rdy", 64'(bus.data_resultRDY), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        start(32'd0, 32'h1234_5678);
        wait_rdy(lat, 40);
        check("lat_zero", 64'(lat), 64'(LAT));
        check("res_zero", 64'(bus.data_result), 64'h0);
        check("exc_zero", 64'(bus.data_exception), 64'h0);

        // randomised signed operands with corner values
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clock);
            start(pick(), pick());
            wait_rdy(lat, 40);
            check("lat_rand", 64'(lat), 64'(LAT));
        end

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
